// File: rtl/me_job_scheduler.sv
// Round-robin scheduler sharing one motion-estimation core among NREQ macroblock
// requesters: drives the core's start/completed handshake, guards it with a timeout
// and returns the result with a one-cycle done pulse.
//
// Handshake with the core: me_start rises when a job is granted and stays high for
// the whole search; the core raises me_completed with valid result data; me_start
// then drops and is held low for the RESP cycle plus GAP_CYCLES so the core
// re-initialises before the next job.
module me_job_scheduler #(
  parameter int NREQ       = 4,
  parameter int ID_W       = 6,
  parameter int TIMEOUT    = 4200,
  parameter int GAP_CYCLES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*ID_W-1:0] req_id,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic [7:0]           res_dist,
  output logic [3:0]           res_mx,
  output logic [3:0]           res_my,
  output logic                 res_err,
  output logic                 busy,
  output logic                 me_start,
  output logic [ID_W-1:0]      me_block_id,
  input  logic                 me_completed,
  input  logic [7:0]           me_best_dist,
  input  logic [3:0]           me_motion_x,
  input  logic [3:0]           me_motion_y
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = 13;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic [GAP_W-1:0] gcnt;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic [ID_W-1:0]  pick_id;
  int               j;

  // First requester after the last served one, wrapping modulo NREQ.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    pick_id    = '0;
    j          = 0;
    for (int i = 1; i <= NREQ; i++) begin
      j = (int'(last) + i) % NREQ;
      if (!pick_valid && req[j]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(j);
        pick_id    = req_id[j*ID_W +: ID_W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      last        <= IDX_W'(NREQ - 1);
      idx         <= '0;
      cnt         <= '0;
      gcnt        <= '0;
      grant       <= '0;
      done        <= '0;
      res_dist    <= 8'hFF;
      res_mx      <= '0;
      res_my      <= '0;
      res_err     <= 1'b0;
      busy        <= 1'b0;
      me_start    <= 1'b0;
      me_block_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            idx         <= pick_idx;
            grant       <= NREQ'(1) << pick_idx;
            me_block_id <= pick_id;
            me_start    <= 1'b1;
            cnt         <= '0;
            busy        <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          // A completion on the timeout cycle still counts as a good result.
          if (me_completed) begin
            res_dist <= me_best_dist;
            res_mx   <= me_motion_x;
            res_my   <= me_motion_y;
            res_err  <= 1'b0;
            me_start <= 1'b0;
            done     <= grant;
            state    <= RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            res_dist <= 8'hFF;
            res_mx   <= '0;
            res_my   <= '0;
            res_err  <= 1'b1;
            me_start <= 1'b0;
            done     <= grant;
            state    <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          done  <= '0;
          grant <= '0;
          last  <= idx;
          gcnt  <= '0;
          state <= GAP;
        end
        GAP: begin
          if (gcnt == GAP_W'(GAP_CYCLES - 1)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gcnt <= gcnt + GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_me_job_scheduler.sv
// Self-checking bench for me_job_scheduler: directed scenarios plus randomized jobs,
// with grant order predicted by a round-robin reference model kept in the bench.
module tb_me_job_scheduler;

  localparam int NREQ       = 4;
  localparam int ID_W       = 6;
  localparam int TIMEOUT    = 4200;
  localparam int GAP_CYCLES = 2;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [NREQ*ID_W-1:0] req_id;
  logic [NREQ-1:0]      grant;
  logic [NREQ-1:0]      done;
  logic [7:0]           res_dist;
  logic [3:0]           res_mx;
  logic [3:0]           res_my;
  logic                 res_err;
  logic                 busy;
  logic                 me_start;
  logic [ID_W-1:0]      me_block_id;
  logic                 me_completed;
  logic [7:0]           me_best_dist;
  logic [3:0]           me_motion_x;
  logic [3:0]           me_motion_y;

  int total = 0;
  int bad   = 0;
  int model_last = NREQ - 1;

  me_job_scheduler #(
    .NREQ(NREQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .req_id(req_id),
    .grant(grant), .done(done), .res_dist(res_dist), .res_mx(res_mx),
    .res_my(res_my), .res_err(res_err), .busy(busy), .me_start(me_start),
    .me_block_id(me_block_id), .me_completed(me_completed),
    .me_best_dist(me_best_dist), .me_motion_x(me_motion_x),
    .me_motion_y(me_motion_y)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arbiter: first asserted requester after the last one served.
  function automatic int pick(input logic [NREQ-1:0] r, input int lst);
    int n;
    for (int i = 1; i <= NREQ; i++) begin
      n = (lst + i) % NREQ;
      if (r[n]) return n;
    end
    return -1;
  endfunction

  // Plays the core for one job and checks grant, hold time, result and gap.
  task automatic run_job(input int lat, input bit complete, input logic [7:0] d,
                         input logic [3:0] x, input logic [3:0] y, input int drop_at,
                         input bit spurious, input logic [NREQ-1:0] next_req,
                         output int owner);
    int waited, eff, exp_idx, hi_cnt;
    logic [ID_W-1:0] exp_id;
    logic [7:0] exp_d;
    logic [3:0] exp_x, exp_y;
    owner   = -1;
    exp_idx = pick(req, model_last);
    exp_id  = (exp_idx >= 0) ? req_id[exp_idx*ID_W +: ID_W] : '0;
    waited  = 0;
    while (me_start !== 1'b1 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (me_start !== 1'b1) begin
      check("grant_wait", {31'd0, me_start}, 32'd1);
      return;
    end
    check("grant", grant, 32'd1 << exp_idx);
    check("block_id", me_block_id, exp_id);
    check("busy_run", busy, 1);
    owner  = exp_idx;
    eff    = complete ? lat : TIMEOUT;
    exp_d  = complete ? d : 8'hFF;
    exp_x  = complete ? x : 4'h0;
    exp_y  = complete ? y : 4'h0;
    hi_cnt = 0;
    me_best_dist = 8'($urandom);
    me_motion_x  = 4'($urandom);
    me_motion_y  = 4'($urandom);
    for (int k = 1; k <= eff; k++) begin
      if (k > 1) @(negedge clock);
      if (me_start === 1'b1 && done === '0) hi_cnt++;
      if (k == 1) req_id = NREQ*ID_W'($urandom);
      if (k == 2) req = NREQ'($urandom);
      if (k == drop_at) req[owner] = 1'b0;
      if (complete && k == eff) begin
        me_completed = 1'b1;
        me_best_dist = d;
        me_motion_x  = x;
        me_motion_y  = y;
      end
    end
    check("start_cycles", hi_cnt, eff);
    @(negedge clock);
    me_completed = 1'b0;
    me_best_dist = 8'($urandom);
    check("start_resp", me_start, 0);
    check("done_resp", done, 32'd1 << owner);
    check("res_dist", res_dist, exp_d);
    check("res_mx", res_mx, exp_x);
    check("res_my", res_my, exp_y);
    check("res_err", res_err, complete ? 0 : 1);
    check("block_id_hold", me_block_id, exp_id);
    model_last = owner;
    req = next_req;
    if (spurious) me_completed = 1'b1;
    for (int g = 1; g <= GAP_CYCLES; g++) begin
      @(negedge clock);
      check("gap_start", me_start, 0);
      check("gap_done", done, 0);
      check("gap_grant", grant, 0);
      check("gap_busy", busy, 1);
      check("gap_res_dist", res_dist, exp_d);
    end
    me_completed = 1'b0;
  endtask

  initial begin
    int owner, waited;
    int rr_exp[5] = '{0, 1, 2, 3, 0};
    logic [NREQ-1:0] nr;

    // Reset state
    reset = 1'b1; req = '0; req_id = '0; me_completed = 1'b0;
    me_best_dist = '0; me_motion_x = '0; me_motion_y = '0;
    repeat (3) @(negedge clock);
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_res_dist", res_dist, 8'hFF);
    check("rst_res_mx", res_mx, 0);
    check("rst_res_my", res_my, 0);
    check("rst_res_err", res_err, 0);
    check("rst_busy", busy, 0);
    check("rst_start", me_start, 0);
    check("rst_block_id", me_block_id, 0);
    reset = 1'b0;

    // Spurious completed while idle
    me_completed = 1'b1; me_best_dist = 8'h12; me_motion_x = 4'h5; me_motion_y = 4'h6;
    repeat (3) @(negedge clock);
    check("idle_spur_done", done, 0);
    check("idle_spur_busy", busy, 0);
    check("idle_spur_dist", res_dist, 8'hFF);
    me_completed = 1'b0;

    // Single nominal job
    req_id[5:0] = 6'd9; req = 4'b0001;
    run_job(4112, 1'b1, 8'd0, 4'hD, 4'h3, 0, 1'b0, '0, owner);
    check("single_owner", owner, 0);
    @(negedge clock);
    check("single_idle_busy", busy, 0);

    // Round robin from reset with all requests held
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; model_last = NREQ - 1;
    for (int i = 0; i < 5; i++) begin
      req = 4'b1111;
      run_job($urandom_range(5, 30), 1'b1, 8'($urandom), 4'($urandom), 4'($urandom),
              0, 1'b0, (i == 4) ? 4'b0000 : 4'b1111, owner);
      check("rr_order", owner, rr_exp[i]);
    end

    // Requester 1, then 2 and 0 raised together
    req = 4'b0010;
    run_job(12, 1'b1, 8'h33, 4'h1, 4'h2, 0, 1'b0, 4'b0101, owner);
    check("seq_owner_a", owner, 1);
    run_job(15, 1'b1, 8'h44, 4'h7, 4'h8, 0, 1'b0, 4'b0101, owner);
    check("seq_owner_b", owner, 2);
    run_job(9, 1'b1, 8'h55, 4'hF, 4'h0, 0, 1'b0, 4'b0000, owner);
    check("seq_owner_c", owner, 0);

    // Core never completes, then completes exactly on the timeout cycle
    req = 4'b1000;
    run_job(0, 1'b0, 8'h00, 4'h0, 4'h0, 0, 1'b0, 4'b0100, owner);
    check("timeout_owner", owner, 3);
    run_job(TIMEOUT, 1'b1, 8'h21, 4'h9, 4'h6, 0, 1'b0, 4'b0000, owner);
    check("late_owner", owner, 2);

    // Owner drops req mid-job; new request during RESP/GAP waits; spurious completed
    req = 4'b0001;
    run_job(40, 1'b1, 8'h66, 4'h2, 4'hE, 10, 1'b1, 4'b0010, owner);
    check("drop_owner", owner, 0);
    run_job(7, 1'b1, 8'h77, 4'h3, 4'h4, 0, 1'b0, 4'b0000, owner);
    check("after_gap_owner", owner, 1);

    // Reset in the middle of a search
    req = 4'b0001;
    waited = 0;
    while (me_start !== 1'b1 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    check("mid_rst_started", me_start, 1);
    repeat (1999) @(negedge clock);
    reset = 1'b1; req = 4'b0110;
    @(negedge clock);
    check("mid_rst_start", me_start, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_grant", grant, 0);
    check("mid_rst_dist", res_dist, 8'hFF);
    reset = 1'b0; model_last = NREQ - 1;
    run_job(20, 1'b1, 8'h10, 4'h8, 4'h7, 0, 1'b0, 4'b0000, owner);
    check("post_rst_owner", owner, 1);

    // Randomized jobs against the reference arbiter
    req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
    for (int i = 0; i < 30; i++) begin
      nr = (i == 29) ? '0 : NREQ'($urandom_range(1, (1 << NREQ) - 1));
      req_id = NREQ*ID_W'($urandom);
      run_job($urandom_range(1, 50), 1'b1, 8'($urandom), 4'($urandom), 4'($urandom),
              $urandom_range(0, 20), 1'($urandom), nr, owner);
    end
    @(negedge clock);
    check("final_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
